alu_issue_ctrl: RTL and testbench

Control-unit-side initiator for the ALU request/response interface. It accepts one decoded ALU operation per transaction from the CU, selects operand 2 (rs2 or immediate), and drives dat_ready, operands and the 5-bit ALU op code. It holds the request until the ALU reports ready, then captures the result and flags into a held response for writeback or branch resolution. It also detects illegal op codes and ALU non-response (timeout).

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/alu_op_check.sv | 25 ++
 rtl/alu_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the CU-side ALU issue path: op code values, the
// issue controller state encoding and the response error codes.
// No ports; imported with "import alu_pkg::*;".
// ---------------------------------------------------------------------------
package alu_pkg;

  // Branch comparisons occupy 0-5, register/immediate arithmetic 6-15.
  // Anything with bit 4 set is undefined.
  localparam logic [4:0] OP_BEQ  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd1;
  localparam logic [4:0] OP_BLT  = 5'd2;
  localparam logic [4:0] OP_BGE  = 5'd3;
  localparam logic [4:0] OP_BLTU = 5'd4;
  localparam logic [4:0] OP_BGEU = 5'd5;
  localparam logic [4:0] OP_ADD  = 5'd6;
  localparam logic [4:0] OP_SUB  = 5'd7;
  localparam logic [4:0] OP_SLL  = 5'd8;
  localparam logic [4:0] OP_SLT  = 5'd9;
  localparam logic [4:0] OP_SLTU = 5'd10;
  localparam logic [4:0] OP_XOR  = 5'd11;
  localparam logic [4:0] OP_SRL  = 5'd12;
  localparam logic [4:0] OP_SRA  = 5'd13;
  localparam logic [4:0] OP_OR   = 5'd14;
  localparam logic [4:0] OP_AND  = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ALU     = 2'd3
  } err_code_t;

  // Branch ops are the low block of the op space, up to and including BGEU.
  function automatic logic op_is_branch(input logic [4:0] op);
    return (op <= OP_BGEU);
  endfunction

endpackage

// File: rtl/alu_op_check.sv
// ---------------------------------------------------------------------------
// alu_op_check
// Combinational classifier for a decoded ALU operation.
//   op        in  5  ALU op code
//   use_imm   in  1  operand 2 would come from the immediate
//   legal     out 1  operation may be sent to the ALU
//   is_branch out 1  op is one of the branch comparisons (0-5)
// ---------------------------------------------------------------------------
import alu_pkg::*;

module alu_op_check (
  input  logic [4:0] op,
  input  logic       use_imm,
  output logic       legal,
  output logic       is_branch
);

  // Branches compare two registers and there is no subtract-immediate,
  // so an immediate operand is meaningless for either.
  always_comb begin
    is_branch = op_is_branch(op);
    legal     = ~op[4] & ~(use_imm & (is_branch | (op == OP_SUB)));
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
// Control-unit-side initiator for the ALU request/response interface.
// Accepts one decoded op from the CU, strobes the ALU with its operands,
// waits for alu_ready (bounded by TIMEOUT_CYC), and holds the captured
// result until the consumer takes it.
//
// Ports
//   soc_clk, reset                 clock, synchronous active-high reset
//   issue_valid/issue_ready        CU handshake (ready only in IDLE)
//   issue_op/rs1/rs2/imm/use_imm   decoded operation and operands
//   issue_rd                       destination tag, passed through
//   alu_dat_ready                  request strobe to the ALU
//   alu_dat1/alu_dat2/alu_instr    request operands and op code
//   alu_out/overflow/con_met/zero/err/ready   ALU response
//   res_valid/res_ready            response handshake
//   res_data/rd/is_branch/taken/overflow/zero/err/err_code  held response
// ---------------------------------------------------------------------------
import alu_pkg::*;

module alu_issue_ctrl #(
  parameter int TIMEOUT_CYC = 16,
  localparam int CNT_W      = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic        soc_clk,
  input  logic        reset,

  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_op,
  input  logic [31:0] issue_rs1,
  input  logic [31:0] issue_rs2,
  input  logic [31:0] issue_imm,
  input  logic        issue_use_imm,
  input  logic [4:0]  issue_rd,

  output logic        alu_dat_ready,
  output logic [31:0] alu_dat1,
  output logic [31:0] alu_dat2,
  output logic [4:0]  alu_instr,
  input  logic [31:0] alu_out,
  input  logic        alu_overflow,
  input  logic        alu_con_met,
  input  logic        alu_zero,
  input  logic        alu_err,
  input  logic        alu_ready,

  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic        res_is_branch,
  output logic        res_taken,
  output logic        res_overflow,
  output logic        res_zero,
  output logic        res_err,
  output logic [1:0]  res_err_code
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t          state;
  state_t          next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic            branch_q;
  err_code_t       err_code_q;
  logic            chk_legal;
  logic            chk_is_branch;

  alu_op_check u_op_check (
    .op        (issue_op),
    .use_imm   (issue_use_imm),
    .legal     (chk_legal),
    .is_branch (chk_is_branch)
  );

  assign issue_ready  = (state == IDLE);
  assign res_valid    = (state == DONE);
  assign res_err_code = err_code_q;

  always_ff @(posedge soc_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // alu_ready takes priority over the timeout when both land together.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (issue_valid) next_state = chk_legal ? BUSY : DONE;
      BUSY: if (alu_ready || (wait_cnt == CNT_LAST)) next_state = DONE;
      DONE: if (res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request and response registers. The ALU operands are left untouched
  // outside of issue so they hold their last value while idle.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      wait_cnt      <= '0;
      alu_dat_ready <= 1'b0;
      alu_dat1      <= '0;
      alu_dat2      <= '0;
      alu_instr     <= '0;
      branch_q      <= 1'b0;
      res_data      <= '0;
      res_rd        <= '0;
      res_is_branch <= 1'b0;
      res_taken     <= 1'b0;
      res_overflow  <= 1'b0;
      res_zero      <= 1'b0;
      res_err       <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      unique case (state)
        IDLE: begin
          if (issue_valid) begin
            res_rd <= issue_rd;
            if (chk_legal) begin
              alu_dat1      <= issue_rs1;
              alu_dat2      <= issue_use_imm ? issue_imm : issue_rs2;
              alu_instr     <= issue_op;
              branch_q      <= chk_is_branch;
              alu_dat_ready <= 1'b1;
              wait_cnt      <= '0;
            end else begin
              res_data      <= '0;
              res_is_branch <= 1'b0;
              res_taken     <= 1'b0;
              res_overflow  <= 1'b0;
              res_zero      <= 1'b0;
              res_err       <= 1'b1;
              err_code_q    <= ERR_ILLEGAL;
            end
          end
        end

        BUSY: begin
          wait_cnt <= wait_cnt + CNT_ONE;
          if (alu_ready) begin
            alu_dat_ready <= 1'b0;
            res_data      <= alu_out;
            res_is_branch <= branch_q;
            res_taken     <= alu_con_met & branch_q;
            res_overflow  <= alu_overflow;
            res_zero      <= alu_zero;
            res_err       <= alu_err;
            err_code_q    <= alu_err ? ERR_ALU : ERR_NONE;
          end else if (wait_cnt == CNT_LAST) begin
            alu_dat_ready <= 1'b0;
            res_data      <= '0;
            res_is_branch <= branch_q;
            res_taken     <= 1'b0;
            res_overflow  <= 1'b0;
            res_zero      <= 1'b0;
            res_err       <= 1'b1;
            err_code_q    <= ERR_TIMEOUT;
          end
        end

        DONE: begin
          if (res_ready) wait_cnt <= '0;
        end

        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
// Randomized and directed stimulus for alu_issue_ctrl. A reference ALU
// computes results from the operation semantics, expected responses are
// queued at issue time, and a monitor compares every presented response.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int TIMEOUT_CYC = 16;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  issue_op = '0;
  logic [31:0] issue_rs1 = '0;
  logic [31:0] issue_rs2 = '0;
  logic [31:0] issue_imm = '0;
  logic        issue_use_imm = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        alu_dat_ready;
  logic [31:0] alu_dat1;
  logic [31:0] alu_dat2;
  logic [4:0]  alu_instr;
  logic [31:0] alu_out = '0;
  logic        alu_overflow = 1'b0;
  logic        alu_con_met = 1'b0;
  logic        alu_zero = 1'b0;
  logic        alu_err = 1'b0;
  logic        alu_ready = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic [4:0]  res_rd;
  logic        res_is_branch;
  logic        res_taken;
  logic        res_overflow;
  logic        res_zero;
  logic        res_err;
  logic [1:0]  res_err_code;

  alu_issue_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .soc_clk       (soc_clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_op      (issue_op),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_imm     (issue_imm),
    .issue_use_imm (issue_use_imm),
    .issue_rd      (issue_rd),
    .alu_dat_ready (alu_dat_ready),
    .alu_dat1      (alu_dat1),
    .alu_dat2      (alu_dat2),
    .alu_instr     (alu_instr),
    .alu_out       (alu_out),
    .alu_overflow  (alu_overflow),
    .alu_con_met   (alu_con_met),
    .alu_zero      (alu_zero),
    .alu_err       (alu_err),
    .alu_ready     (alu_ready),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_rd        (res_rd),
    .res_is_branch (res_is_branch),
    .res_taken     (res_taken),
    .res_overflow  (res_overflow),
    .res_zero      (res_zero),
    .res_err       (res_err),
    .res_err_code  (res_err_code)
  );

  always #5 soc_clk = ~soc_clk;

  int cyc = 0;
  always @(posedge soc_clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        no_resp;
    logic [31:0] out;
    logic        ovf;
    logic        con;
    logic        zero;
    logic        err;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        is_br;
    logic        taken;
    logic        ovf;
    logic        zero;
    logic        err;
    logic [1:0]  code;
    logic        full;
    logic        chk_br;
  } exp_t;

  req_t req_q[$];
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int issue_cyc = 0;
  int mon_cyc = 0;
  logic        hold_rr = 1'b0;
  logic [31:0] mon_data;
  logic        mon_is_br, mon_taken;
  logic [1:0]  mon_code;
  logic [43:0] mon_snap;
  logic        prev_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference ALU: results straight from the op semantics.
  function automatic void alu_ref(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic ovf, output logic con);
    res = '0; ovf = 1'b0; con = 1'b0;
    case (op)
      5'd0:  con = (a == b);
      5'd1:  con = (a != b);
      5'd2:  con = ($signed(a) < $signed(b));
      5'd3:  con = ($signed(a) >= $signed(b));
      5'd4:  con = (a < b);
      5'd5:  con = (a >= b);
      5'd6:  begin res = a + b; ovf = (a[31] == b[31]) && (res[31] != a[31]); end
      5'd7:  begin res = a - b; ovf = (a[31] != b[31]) && (res[31] != a[31]); end
      5'd8:  res = a << b[4:0];
      5'd9:  begin con = ($signed(a) < $signed(b)); res = {31'b0, con}; end
      5'd10: begin con = (a < b); res = {31'b0, con}; end
      5'd11: res = a ^ b;
      5'd12: res = a >> b[4:0];
      5'd13: res = 32'($signed(a) >>> b[4:0]);
      5'd14: res = a | b;
      5'd15: res = a & b;
      default: ;
    endcase
    if (op <= 5'd5) res = a - b;
  endfunction

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic use_imm, input logic [4:0] rd,
                               input logic no_resp, input logic force_err);
    int waited;
    req_t r;
    exp_t e;
    logic [31:0] b;
    logic legal, br;
    waited = 0;
    @(negedge soc_clk);
    while (!issue_ready && waited < 200) begin
      @(negedge soc_clk);
      waited++;
    end
    if (!issue_ready) begin
      checkOutput("issue_ready_wait", {63'b0, issue_ready}, 64'd1);
      return;
    end
    b = use_imm ? imm : rs2;
    br = (op < 5'd6);
    legal = (op < 5'd16) && !(use_imm && (br || op == 5'd7));
    e = '{default: '0};
    e.rd = rd;
    if (legal) begin
      r.op = op; r.a = rs1; r.b = b; r.no_resp = no_resp;
      alu_ref(op, rs1, b, r.out, r.ovf, r.con);
      r.zero = (r.out == 32'd0);
      r.err = force_err;
      req_q.push_back(r);
      if (no_resp) begin
        e.err = 1'b1; e.code = 2'd2;
      end else begin
        e.data = r.out; e.is_br = br; e.taken = r.con && br; e.ovf = r.ovf;
        e.zero = r.zero; e.err = force_err; e.code = force_err ? 2'd3 : 2'd0;
        e.full = 1'b1; e.chk_br = 1'b1;
      end
    end else begin
      e.err = 1'b1; e.code = 2'd1; e.chk_br = 1'b1;
    end
    exp_q.push_back(e);
    issue_valid = 1'b1; issue_op = op; issue_rs1 = rs1; issue_rs2 = rs2;
    issue_imm = imm; issue_use_imm = use_imm; issue_rd = rd;
    issue_cyc = cyc;
    @(posedge soc_clk);
    #1 issue_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int waited;
    waited = 0;
    @(negedge soc_clk);
    while (!(exp_q.size() == 0 && issue_ready && !res_valid) && waited < 300) begin
      @(negedge soc_clk);
      waited++;
    end
    checkOutput("drain", {63'b0, (exp_q.size() == 0 && issue_ready)}, 64'd1);
  endtask

  // Consumer: random acceptance unless backpressure is being held.
  always @(negedge soc_clk) res_ready <= hold_rr ? 1'b0 : ($urandom_range(0, 3) != 0);

  // ALU model: checks each request, holds checks while busy, answers after
  // two cycles unless told to stay silent. Stray alu_ready pulses while no
  // request is open must be ignored by the controller.
  initial begin
    req_t cur;
    logic served;
    int countdown;
    served = 1'b0;
    countdown = -1;
    forever begin
      @(negedge soc_clk);
      if (alu_dat_ready && !reset) begin
        if (!served) begin
          served = 1'b1;
          alu_ready = 1'b0;
          if (req_q.size() == 0) begin
            checkOutput("unexpected_alu_request", 64'd1, 64'd0);
            cur = '{default: '0};
            cur.no_resp = 1'b1;
          end else begin
            cur = req_q.pop_front();
          end
          countdown = cur.no_resp ? -1 : 1;
        end
        checkOutput("alu_dat1", {32'b0, alu_dat1}, {32'b0, cur.a});
        checkOutput("alu_dat2", {32'b0, alu_dat2}, {32'b0, cur.b});
        checkOutput("alu_instr", {59'b0, alu_instr}, {59'b0, cur.op});
        if (countdown == 0) begin
          alu_ready = 1'b1; alu_out = cur.out; alu_overflow = cur.ovf;
          alu_con_met = cur.con; alu_zero = cur.zero; alu_err = cur.err;
          countdown = -1;
        end else if (countdown > 0) begin
          countdown--;
        end
      end else begin
        served = 1'b0;
        countdown = -1;
        alu_ready = ($urandom_range(0, 7) == 0);
        alu_out = $urandom;
        alu_overflow = 1'(($urandom_range(0, 1)));
        alu_con_met = 1'(($urandom_range(0, 1)));
        alu_zero = 1'(($urandom_range(0, 1)));
        alu_err = 1'(($urandom_range(0, 1)));
      end
    end
  end

  // Monitor: compare each new response, then check it stays put.
  initial begin
    exp_t e;
    logic [43:0] snap;
    forever begin
      @(negedge soc_clk);
      snap = {res_data, res_rd, res_is_branch, res_taken, res_overflow, res_zero, res_err, res_err_code};
      if (res_valid && !prev_valid && !reset) begin
        mon_cyc = cyc; mon_data = res_data; mon_is_br = res_is_branch;
        mon_taken = res_taken; mon_code = res_err_code; mon_snap = snap;
        checkOutput("dat_ready_in_done", {63'b0, alu_dat_ready}, 64'd0);
        checkOutput("issue_ready_in_done", {63'b0, issue_ready}, 64'd0);
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_response", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("res_err", {63'b0, res_err}, {63'b0, e.err});
          checkOutput("res_err_code", {62'b0, res_err_code}, {62'b0, e.code});
          checkOutput("res_data", {32'b0, res_data}, {32'b0, e.data});
          checkOutput("res_rd", {59'b0, res_rd}, {59'b0, e.rd});
          if (e.chk_br) checkOutput("res_is_branch", {63'b0, res_is_branch}, {63'b0, e.is_br});
          if (e.full) begin
            checkOutput("res_taken", {63'b0, res_taken}, {63'b0, e.taken});
            checkOutput("res_overflow", {63'b0, res_overflow}, {63'b0, e.ovf});
            checkOutput("res_zero", {63'b0, res_zero}, {63'b0, e.zero});
          end
        end
      end else if (res_valid && prev_valid) begin
        checkOutput("res_stable", {20'b0, snap}, {20'b0, mon_snap});
      end
      prev_valid = res_valid;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a, b2;
    logic [4:0] op;
    repeat (3) @(negedge soc_clk);
    reset = 1'b0;
    @(negedge soc_clk);
    checkOutput("reset_issue_ready", {63'b0, issue_ready}, 64'd1);
    checkOutput("reset_res_valid", {63'b0, res_valid}, 64'd0);
    checkOutput("reset_dat_ready", {63'b0, alu_dat_ready}, 64'd0);
    checkOutput("reset_res_data", {32'b0, res_data}, 64'd0);
    checkOutput("reset_alu_dat1", {32'b0, alu_dat1}, 64'd0);
    checkOutput("reset_res_err_code", {62'b0, res_err_code}, 64'd0);

    $display("[TB] directed ADD with immediate");
    applyStimulus(5'd6, 32'd5, 32'h0, 32'hFFFF_FFFD, 1'b1, 5'd3, 1'b0, 1'b0);
    waitIdle();
    checkOutput("add_res_data", {32'b0, mon_data}, 64'd2);
    checkOutput("add_res_code", {62'b0, mon_code}, 64'd0);

    $display("[TB] directed BEQ taken / not taken");
    applyStimulus(5'd0, 32'h1234, 32'h1234, 32'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    waitIdle();
    checkOutput("beq_taken", {62'b0, mon_is_br, mon_taken}, 64'd3);
    applyStimulus(5'd0, 32'h1234, 32'h1235, 32'h0, 1'b0, 5'd4, 1'b0, 1'b0);
    waitIdle();
    checkOutput("beq_not_taken", {62'b0, mon_is_br, mon_taken}, 64'd2);

    $display("[TB] directed illegal ops");
    applyStimulus(5'd20, 32'h1, 32'h2, 32'h3, 1'b0, 5'd5, 1'b0, 1'b0);
    waitIdle();
    checkOutput("illegal_latency", 64'(mon_cyc - issue_cyc), 64'd1);
    checkOutput("illegal_code", {62'b0, mon_code}, 64'd1);
    applyStimulus(5'd7, 32'h1, 32'h2, 32'h3, 1'b1, 5'd6, 1'b0, 1'b0);
    waitIdle();
    checkOutput("subi_code", {62'b0, mon_code}, 64'd1);
    applyStimulus(5'd2, 32'h1, 32'h2, 32'h3, 1'b1, 5'd6, 1'b0, 1'b0);
    waitIdle();
    checkOutput("branch_imm_code", {62'b0, mon_code}, 64'd1);

    $display("[TB] directed timeout");
    applyStimulus(5'd14, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0, 1'b0, 5'd7, 1'b1, 1'b0);
    waitIdle();
    checkOutput("timeout_latency", 64'(mon_cyc - issue_cyc), 64'(TIMEOUT_CYC + 1));
    checkOutput("timeout_code", {62'b0, mon_code}, 64'd2);
    checkOutput("timeout_dat_ready", {63'b0, alu_dat_ready}, 64'd0);

    $display("[TB] directed backpressure");
    hold_rr = 1'b1;
    @(negedge soc_clk);
    applyStimulus(5'd11, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0, 1'b0, 5'd9, 1'b0, 1'b0);
    for (int w = 0; w < 20 && !res_valid; w++) @(negedge soc_clk);
    checkOutput("bp_res_valid", {63'b0, res_valid}, 64'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge soc_clk);
      checkOutput("bp_issue_ready", {63'b0, issue_ready}, 64'd0);
      checkOutput("bp_res_valid_held", {63'b0, res_valid}, 64'd1);
    end
    checkOutput("bp_res_data", {32'b0, res_data}, 64'hFF00_FF00);
    hold_rr = 1'b0;
    waitIdle();

    $display("[TB] directed reset while busy");
    applyStimulus(5'd6, 32'd1, 32'd1, 32'h0, 1'b0, 5'd1, 1'b1, 1'b0);
    repeat (3) @(negedge soc_clk);
    checkOutput("busy_before_reset", {63'b0, alu_dat_ready}, 64'd1);
    reset = 1'b1;
    @(negedge soc_clk);
    checkOutput("rst_busy_dat_ready", {63'b0, alu_dat_ready}, 64'd0);
    checkOutput("rst_busy_res_valid", {63'b0, res_valid}, 64'd0);
    checkOutput("rst_busy_issue_ready", {63'b0, issue_ready}, 64'd1);
    reset = 1'b0;
    exp_q.delete();
    req_q.delete();
    @(negedge soc_clk);

    $display("[TB] randomized operations");
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
      a = $urandom;
      b2 = ($urandom_range(0, 3) == 0) ? a : $urandom;
      applyStimulus(op, a, b2, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0));
    end
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
